// File: rtl/mmio_uart_port_if.sv
// Data-memory bus seen by MMIO responders: the core drives the request, the responder
// returns combinational Sel/ReadData that the top level muxes against the data RAM.
interface mmio_uart_port_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Sel;

  modport master (output MemWrite, MemRead, Address, WriteData, input ReadData, Sel);
  modport slave  (input MemWrite, MemRead, Address, WriteData, output ReadData, Sel);
endinterface

// File: rtl/mmio_uart_port.sv
// MMIO responder: TXDATA/STATUS/PORTOUT/PORTIN registers and a FIFO-fed UART transmitter.
// Define MMIO_UART_PARITY_EN to add an even-parity bit between data and stop.
module mmio_uart_port #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  mmio_uart_port_if.slave bus,
  input  logic [7:0]      PortIn,
  output logic [31:0]     PortOut,
  output logic            Tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_TOP = TW'(CLKS_PER_BIT - 1);
`ifdef MMIO_UART_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_PORTOUT = 2'd2;
  localparam logic [1:0] OFF_PORTIN  = 2'd3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

  logic [1:0]    offset;
  logic          wrEn, push, accept, pop, full, empty, busy;
  logic          unusedAddrBits;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [7:0]    sync1, sync2;
  logic [31:0]   statusWord;

  txState_t      state, stateNext;
  logic [TW-1:0] bitTimer, timerNext;
  logic [2:0]    bitIdx, idxNext;
  logic [7:0]    shiftReg;

  assign bus.Sel        = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign offset         = bus.Address[3:2];
  assign unusedAddrBits = ^bus.Address[1:0];
  assign wrEn           = bus.MemWrite && bus.Sel;
  assign push           = wrEn && (offset == OFF_TXDATA);
  assign full           = (count == CW'(FIFO_DEPTH));
  assign empty          = (count == '0);
  assign busy           = (state != IDLE);
  // A push into a full FIFO still lands when the transmitter frees a slot on the same edge.
  assign accept         = push && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      PortOut <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      if (wrEn && offset == OFF_PORTOUT) PortOut <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (wrEn && offset == OFF_STATUS && bus.WriteData[3]) overflow <= 1'b0;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) fifoMem[wrPtr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bitTimer <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      bitTimer <= timerNext;
      bitIdx   <= idxNext;
      if (pop) shiftReg <= fifoMem[rdPtr];
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext = state;
    timerNext = (bitTimer == '0) ? BIT_TOP : bitTimer - TW'(1);
    idxNext   = bitIdx;
    pop       = 1'b0;
    Tx        = 1'b1;
    unique case (state)
      IDLE: begin
        timerNext = BIT_TOP;
        if (!empty) begin
          pop       = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        Tx = 1'b0;
        if (bitTimer == '0) begin
          stateNext = DATA;
          idxNext   = '0;
        end
      end
      DATA: begin
        Tx = shiftReg[bitIdx];
        if (bitTimer == '0) begin
          idxNext = bitIdx + 3'd1;
`ifdef MMIO_UART_PARITY_EN
          if (bitIdx == 3'd7) stateNext = PARITY;
`else
          if (bitIdx == 3'd7) stateNext = STOP;
`endif
        end
      end
      PARITY: begin
        Tx = ^shiftReg;
        if (bitTimer == '0) stateNext = STOP;
      end
      STOP: begin
        if (bitTimer == '0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign statusWord = {20'd0, PARITY_EN, 7'(count), overflow, empty, full, busy};

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead && bus.Sel) begin
      unique case (offset)
        OFF_STATUS:  bus.ReadData = statusWord;
        OFF_PORTOUT: bus.ReadData = PortOut;
        OFF_PORTIN:  bus.ReadData = {24'd0, sync2};
        default:     bus.ReadData = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_port.sv
// Randomized bench for mmio_uart_port against a queue-based reference model that predicts
// registers and the exact Tx waveform from frame position arithmetic.
module tb_mmio_uart_port;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
`ifdef MMIO_UART_PARITY_EN
  localparam int   FRAME_BITS = 11;
  localparam logic PAR_EN     = 1'b1;
`else
  localparam int   FRAME_BITS = 10;
  localparam logic PAR_EN     = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Tx;

  mmio_uart_port_if bus();

  mmio_uart_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .PortIn(PortIn), .PortOut(PortOut), .Tx(Tx)
  );

  always #5 clk = ~clk;

  int numChecks = 0;
  int numErrors = 0;

  // Reference model: FIFO as a queue, transmitter as "cycles left in the current frame".
  logic [7:0]  fifoQ[$];
  int          txTimer;
  logic [7:0]  txByte;
  logic        ovf;
  logic [31:0] portOutM;
  logic [7:0]  pinD1, pinD2;

  logic [31:0] lastRead, lastPortOut;
  logic        lastSel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] regAddr(input int off);
    return BASE + 32'(off * 4);
  endfunction

  function automatic void modelReset();
    fifoQ.delete();
    txTimer  = 0;
    txByte   = '0;
    ovf      = 1'b0;
    portOutM = '0;
    pinD1    = '0;
    pinD2    = '0;
  endfunction

  function automatic int curSlot();
    return (FRAME_BITS * CPB - txTimer) / CPB;
  endfunction

  function automatic logic [31:0] modelStatus();
    int n = fifoQ.size();
    return {20'd0, PAR_EN, 7'(n), ovf, (n == 0), (n == DEPTH), (txTimer != 0)};
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] off);
    case (off)
      2'd1:    return modelStatus();
      2'd2:    return portOutM;
      2'd3:    return {24'd0, pinD2};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelTx();
    int s;
    if (txTimer == 0) return 1'b1;
    s = curSlot();
    if (s == 0) return 1'b0;
    if (s <= 8) return txByte[s-1];
    if (PAR_EN && s == 9) return ^txByte;
    return 1'b1;
  endfunction

  function automatic void modelEdge(input logic we, input logic [31:0] a, input logic [31:0] d,
                                    input logic [7:0] pin);
    logic sel     = (a[31:4] == BASE[31:4]);
    logic popNow  = (txTimer == 0) && (fifoQ.size() != 0);
    logic wasFull = (fifoQ.size() == DEPTH);
    if (txTimer > 0) txTimer--;
    if (popNow) begin
      txByte  = fifoQ.pop_front();
      txTimer = FRAME_BITS * CPB;
    end
    if (we && sel) begin
      case (a[3:2])
        2'd0: if (!wasFull || popNow) fifoQ.push_back(d[7:0]); else ovf = 1'b1;
        2'd1: if (d[3]) ovf = 1'b0;
        2'd2: portOutM = d;
        default: ;
      endcase
    end
    pinD2 = pinD1;
    pinD1 = pin;
  endfunction

  // One clock: drive at the falling edge, compare outputs, then advance the model at the rising edge.
  task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                      input logic [7:0] pin);
    logic expSel;
    @(negedge clk);
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.Address   = a;
    bus.WriteData = d;
    PortIn        = pin;
    #1;
    expSel = (a[31:4] == BASE[31:4]);
    check("sel", bus.Sel, expSel);
    check("rdata", bus.ReadData, (re && expSel) ? modelRead(a[3:2]) : 32'd0);
    check("tx", Tx, modelTx());
    check("portout", PortOut, portOutM);
    lastRead    = bus.ReadData;
    lastPortOut = PortOut;
    lastSel     = bus.Sel;
    @(posedge clk);
    modelEdge(we, a, d, pin);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (fifoQ.size() == 0 && txTimer == 0) break;
      step(1'b0, 1'b1, regAddr(1), 32'd0, 8'($urandom));
    end
    step(1'b0, 1'b1, regAddr(1), 32'd0, 8'($urandom));
    check("idle_status", lastRead & 32'h7, 32'h4);
  endtask

  task automatic busIdle();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
  endtask

  initial begin
    reset  = 1'b0;
    PortIn = '0;
    busIdle();
    modelReset();

    repeat (2) @(negedge clk);
    bus.MemRead = 1'b1;
    bus.Address = regAddr(1);
    #1;
    check("reset_tx", Tx, 32'd1);
    check("reset_portout", PortOut, 32'd0);
    check("reset_status", bus.ReadData, {20'd0, PAR_EN, 11'h004});
    busIdle();
    reset = 1'b1;
    @(posedge clk);
    modelEdge(1'b0, 32'd0, 32'd0, PortIn);

    step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
    check("idle_status_word", lastRead, {20'd0, PAR_EN, 11'h004});

    // Single byte: frame shape checked cycle by cycle through the model.
    step(1'b1, 1'b0, regAddr(0), 32'h0000_00A5, 8'd0);
    repeat (40) step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
    if (FRAME_BITS == 10) begin
      step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
      check("busy_last_cycle", lastRead & 32'h1, 32'h1);
      step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
      check("busy_cleared", lastRead & 32'h1, 32'h0);
    end
    waitIdle(200);

    // Overflow: ten back-to-back stores from empty.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, regAddr(0), 32'h10 + 32'(i), 8'd0);
    step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
    check("ovf_status", lastRead, {20'd0, PAR_EN, 11'h08B});
    step(1'b1, 1'b0, regAddr(1), 32'h8, 8'd0);
    step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
    check("ovf_cleared", lastRead, {20'd0, PAR_EN, 11'h083});
    waitIdle(1000);

    // Output and input ports.
    step(1'b1, 1'b0, regAddr(2), 32'hDEAD_BEEF, 8'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 8'h3C);
    check("portout_beef", lastPortOut, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'd0, 32'd0, 8'h3C);
    step(1'b0, 1'b1, regAddr(3), 32'd0, 8'h3C);
    check("portin_3c", lastRead, 32'h0000_003C);

    // Decode boundaries.
    step(1'b1, 1'b1, BASE + 32'd16, 32'h0000_00FF, 8'd0);
    check("decode_sel", 32'(lastSel), 32'd0);
    check("decode_rdata", lastRead, 32'd0);
    step(1'b0, 1'b0, regAddr(2), 32'd0, 8'd0);
    check("noread_rdata", lastRead, 32'd0);
    step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
    check("decode_status", lastRead, {20'd0, PAR_EN, 11'h004});

    // Reset during data bit 3 of the first of three queued frames.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, regAddr(0), 32'($urandom), 8'd0);
    for (int i = 0; i < 200; i++) begin
      if (txTimer != 0 && curSlot() == 4) break;
      step(1'b0, 1'b0, 32'd0, 32'd0, 8'd0);
    end
    #3;
    reset       = 1'b0;
    bus.MemRead = 1'b1;
    bus.Address = regAddr(1);
    #1;
    check("midframe_tx", Tx, 32'd1);
    check("midframe_status", bus.ReadData, {20'd0, PAR_EN, 11'h004});
    check("midframe_portout", PortOut, 32'd0);
    modelReset();
    repeat (2) @(negedge clk);
    busIdle();
    reset = 1'b1;
    @(posedge clk);
    modelEdge(1'b0, 32'd0, 32'd0, PortIn);
    repeat (60) step(1'b0, 1'b1, regAddr(1), 32'd0, 8'd0);
    waitIdle(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int op = $urandom_range(0, 15);
      logic [7:0] pin = 8'($urandom);
      logic [31:0] d = $urandom;
      logic re = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, regAddr(0), 32'($urandom), pin);
      end else if (op == 0) step(1'b1, re, regAddr(0), d, pin);
      else if (op == 1) step(1'b1, re, regAddr(1), d, pin);
      else if (op == 2) step(1'b1, re, regAddr(2), d, pin);
      else if (op <= 8) step(1'b0, 1'b1, regAddr($urandom_range(0, 3)) + 32'($urandom_range(0, 3)), d, pin);
      else if (op == 9) step(1'($urandom_range(0, 1)), re, $urandom, d, pin);
      else step(1'b0, re, regAddr($urandom_range(0, 3)), d, pin);
    end
    waitIdle(2000);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end
endmodule
